keypad_scan_unit: RTL and testbench

//   Input-side counterpart of the 7-seg scan driver: scans a 4x4 active-low matrix keypad

---
 rtl/keypad_scan_unit.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scan_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_unit.sv
// Scans a 4x4 active-low matrix keypad column by column, debounces whole-keypad
// scan results and emits one key event per press, shifting codes into an 8-digit register.
module keypad_scan_unit #(
  parameter logic [15:0] SCAN_TICKS     = 16'd25000,
  parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] digits
);

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

  // Row synchronizer
  logic [3:0] row_meta, row_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Column scanning
  logic        active;
  logic [15:0] tick_cnt;
  logic [1:0]  col_idx, col_next;
  logic [15:0] press_bits;   // indexed by key code {row, col}, 1 = pressed
  logic [15:0] scan_bits;
  logic        last_tick;
  logic [4:0]  ones;
  logic [3:0]  single_code;
  res_t        res_kind;
  logic [3:0]  res_code;
  logic        scan_done;

  assign last_tick = active && (tick_cnt == SCAN_TICKS - 16'd1);
  assign col_next  = col_idx + 2'd1;

  // The column being captured this edge is merged in so the column-3 result sees all 16 bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    scan_bits = press_bits;
    for (int r = 0; r < 4; r++)
      scan_bits[{2'(r), col_idx}] = ~row_sync[r];
    ones        = '0;
    single_code = '0;
    for (int k = 0; k < 16; k++) begin
      if (scan_bits[k]) begin
        ones        = ones + 5'd1;
        single_code = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      tick_cnt   <= '0;
      col_idx    <= '0;
      col_out    <= 4'b1111;
      press_bits <= '0;
      res_kind   <= RES_NONE;
      res_code   <= '0;
      scan_done  <= 1'b0;
    end else if (!en) begin
      active    <= 1'b0;
      tick_cnt  <= '0;
      col_idx   <= '0;
      col_out   <= 4'b1111;
      scan_done <= 1'b0;
    end else if (!active) begin
      active    <= 1'b1;
      tick_cnt  <= '0;
      col_idx   <= '0;
      col_out   <= 4'b1110;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (last_tick) begin
        press_bits <= scan_bits;
        tick_cnt   <= '0;
        col_idx    <= col_next;
        col_out    <= ~(4'b0001 << col_next);
        if (col_idx == 2'd3) begin
          res_code  <= single_code;
          scan_done <= 1'b1;
          if (ones == 5'd0)      res_kind <= RES_NONE;
          else if (ones == 5'd1) res_kind <= RES_SINGLE;
          else                   res_kind <= RES_MULTI;
        end
      end else begin
        tick_cnt <= tick_cnt + 16'd1;
      end
    end
  end

  // Debounce FSM
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic [3:0] cand, cand_n;
  logic       do_accept, do_release;

  assign cnt_inc = cnt + 8'd1;

  // Acceptance happens on the edge that would enter ACCEPT, so it is a transition into HELD.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cand_n     = cand;
    do_accept  = 1'b0;
    do_release = 1'b0;
    if (scan_done) begin
      unique case (state)
        ST_IDLE: begin
          if (res_kind == RES_SINGLE) begin
            cand_n = res_code;
            cnt_n  = 8'd1;
            if (DEBOUNCE_SCANS == 8'd1) do_accept = 1'b1;
            else                        state_n   = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (res_kind == RES_SINGLE && res_code == cand) begin
            if (cnt_inc == DEBOUNCE_SCANS) do_accept = 1'b1;
            else                           cnt_n     = cnt_inc;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_HELD: begin
          if (res_kind == RES_NONE) begin
            if (cnt_inc == DEBOUNCE_SCANS) begin
              state_n    = ST_IDLE;
              cnt_n      = '0;
              do_release = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
      if (do_accept) begin
        state_n = ST_HELD;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
      digits    <= '0;
    end else if (!en) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_valid <= do_accept;
      if (do_accept) begin
        key_code <= cand;
        digits   <= {digits[27:0], cand};
        key_down <= 1'b1;
      end else if (do_release) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_unit.sv
// Directed bench for keypad_scan_unit with a behavioural 4x4 keypad (SCAN_TICKS=4, DEBOUNCE_SCANS=2).
module tb_keypad_scan_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] digits;

  logic [15:0] keys = '0;  // bit {row, col} set = that key is pressed
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          kv_cycles = 0;

  keypad_scan_unit #(.SCAN_TICKS(16'd4), .DEBOUNCE_SCANS(8'd2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down), .digits(digits)
  );

  always #5 clk = ~clk;

  // A row reads low when a pressed key on it sits in a driven (low) column.
  assign row_in = {~|(keys[15:12] & ~col_out), ~|(keys[11:8] & ~col_out),
                   ~|(keys[7:4]   & ~col_out), ~|(keys[3:0]  & ~col_out)};

  // Cycles with key_valid high; a stretched pulse counts more than once.
  always @(negedge clk) if (key_valid === 1'b1) kv_cycles++;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge where column 0 has just been driven.
  task automatic wait_scan_start();
    logic [3:0] prev;
    bit found;
    prev  = col_out;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110 && prev != 4'b1110) found = 1;
      prev = col_out;
    end
    total_cnt++;
    if (!found) $display("FAIL scan_align: col_out=%b, no scan start within 64 cycles", col_out);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    keys  = '0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
    total_cnt++; if (col_out !== 4'b1111) $display("FAIL reset_col: got %b want 1111", col_out); else pass_cnt++;
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid); else pass_cnt++;
    total_cnt++; if (key_down !== 1'b0) $display("FAIL reset_down: got %b want 0", key_down); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", key_code); else pass_cnt++;
    total_cnt++; if (digits !== 32'h0) $display("FAIL reset_digits: got %h want 0", digits); else pass_cnt++;
  endtask

  task automatic test_scan();
    int errs;
    logic [3:0] exp;
    errs = 0;
    en = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((i / 4) % 4));
      if (col_out !== exp) begin
        if (errs == 0) $display("FAIL scan_seq: cycle %0d got %b want %b", i, col_out, exp);
        errs++;
      end
    end
    total_cnt++; if (errs == 0) pass_cnt++;
    total_cnt++; if (kv_cycles !== 0) $display("FAIL scan_idle_valid: got %0d pulses want 0", kv_cycles); else pass_cnt++;
  endtask

  task automatic test_press();
    int kv0;
    kv0 = kv_cycles;
    wait_scan_start();
    keys = 16'h0040;  // key 6 = row1/col2
    wait_cycles(80);
    total_cnt++; if (kv_cycles - kv0 !== 1) $display("FAIL press_once: got %0d pulse cycles want 1", kv_cycles - kv0); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h6) $display("FAIL press_code: got %h want 6", key_code); else pass_cnt++;
    total_cnt++; if (digits !== 32'h00000006) $display("FAIL press_digits: got %h want 00000006", digits); else pass_cnt++;
    total_cnt++; if (key_down !== 1'b1) $display("FAIL press_down: got %b want 1", key_down); else pass_cnt++;
    keys = '0;
    wait_cycles(16);
    total_cnt++; if (key_down !== 1'b1) $display("FAIL release_early: got %b want 1", key_down); else pass_cnt++;
    wait_cycles(48);
    total_cnt++; if (key_down !== 1'b0) $display("FAIL release_down: got %b want 0", key_down); else pass_cnt++;
    total_cnt++; if (kv_cycles - kv0 !== 1) $display("FAIL release_valid: got %0d pulse cycles want 1", kv_cycles - kv0); else pass_cnt++;
  endtask

  task automatic test_reject();
    int kv0;
    kv0 = kv_cycles;
    wait_scan_start();
    keys = 16'h0040;
    wait_cycles(16);
    keys = '0;
    wait_cycles(40);
    total_cnt++; if (kv_cycles !== kv0) $display("FAIL short_press: got %0d pulse cycles want 0", kv_cycles - kv0); else pass_cnt++;
    keys = 16'h0240;  // keys 6 and 9 together
    wait_cycles(64);
    total_cnt++; if (kv_cycles !== kv0) $display("FAIL multi_press: got %0d pulse cycles want 0", kv_cycles - kv0); else pass_cnt++;
    total_cnt++; if (key_down !== 1'b0) $display("FAIL multi_down: got %b want 0", key_down); else pass_cnt++;
    keys = '0;
    wait_cycles(48);
    total_cnt++; if (digits !== 32'h00000006) $display("FAIL reject_digits: got %h want 00000006", digits); else pass_cnt++;
  endtask

  task automatic test_min_debounce();
    int kv0;
    kv0 = kv_cycles;
    wait_scan_start();
    keys = 16'h8000;  // key F = row3/col3
    wait_cycles(34);
    keys = '0;
    wait_cycles(4);
    total_cnt++; if (kv_cycles - kv0 !== 1) $display("FAIL keyf_once: got %0d pulse cycles want 1", kv_cycles - kv0); else pass_cnt++;
    total_cnt++; if (key_code !== 4'hF) $display("FAIL keyf_code: got %h want F", key_code); else pass_cnt++;
    total_cnt++; if (digits !== 32'h0000006F) $display("FAIL keyf_digits: got %h want 0000006F", digits); else pass_cnt++;
    wait_cycles(64);
  endtask

  task automatic test_abort();
    int kv0;
    kv0 = kv_cycles;
    wait_scan_start();
    keys = 16'h0040;
    wait_cycles(20);  // one matching scan seen: FSM in CONFIRM
    en = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (col_out !== 4'b1111) $display("FAIL en_col: got %b want 1111", col_out); else pass_cnt++;
    wait_cycles(40);
    total_cnt++; if (kv_cycles !== kv0) $display("FAIL en_valid: got %0d pulse cycles want 0", kv_cycles - kv0); else pass_cnt++;
    total_cnt++; if (digits !== 32'h0000006F) $display("FAIL en_digits: got %h want 0000006F", digits); else pass_cnt++;
    total_cnt++; if (key_code !== 4'hF) $display("FAIL en_code: got %h want F", key_code); else pass_cnt++;
    keys = '0;
    wait_cycles(2);
    en = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (col_out !== 4'b1110) $display("FAIL en_restart: got %b want 1110", col_out); else pass_cnt++;
    // Reach HELD with key 9, then pulse reset mid-cycle.
    wait_scan_start();
    keys = 16'h0200;
    wait_cycles(50);
    total_cnt++; if (key_down !== 1'b1 || digits !== 32'h000006F9) $display("FAIL held_setup: down=%b digits=%h want 1 000006F9", key_down, digits); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (col_out !== 4'b1111) $display("FAIL rst_col: got %b want 1111", col_out); else pass_cnt++;
    total_cnt++; if (key_down !== 1'b0) $display("FAIL rst_down: got %b want 0", key_down); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h0) $display("FAIL rst_code: got %h want 0", key_code); else pass_cnt++;
    total_cnt++; if (digits !== 32'h0) $display("FAIL rst_digits: got %h want 0", digits); else pass_cnt++;
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", key_valid); else pass_cnt++;
    keys = '0;
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press();
    test_reject();
    test_min_debounce();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
